// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
// Imported by the divider top and its restoring-step datapath.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

  localparam logic DivResultReady = 1'b1;
  localparam logic DivStart       = 1'b1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left by one and
// subtract the divisor when it fits, shifting the outcome into quo[0].
module div_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0]   w_remWide;
  logic [DATA_W-1:0] w_diff;
  logic              w_fits;

  // The shifted remainder can carry into bit DATA_W, so the compare is done
  // one bit wider; the subtraction result always fits back into DATA_W bits.
  assign w_remWide = {i_rem, i_quo[DATA_W-1]};
  assign w_fits    = w_remWide >= {1'b0, i_divisor};
  assign w_diff    = w_remWide[DATA_W-1:0] - i_divisor;

  assign o_rem = w_fits ? w_diff : w_remWide[DATA_W-1:0];
  assign o_quo = {i_quo[DATA_W-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider that stalls EX for 32 restoring
// steps and returns {remainder, quotient} for the HI/LO write.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_signed;
  logic                r_signDividend;
  logic                r_signDivisor;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_accept;
  logic                w_dividendNeg;
  logic                w_divisorNeg;
  logic [DATA_W-1:0]   w_dividendAbs;
  logic [DATA_W-1:0]   w_divisorAbs;
  logic [DATA_W-1:0]   w_stepRem;
  logic [DATA_W-1:0]   w_stepQuo;
  logic                w_negQuo;
  logic                w_negRem;
  logic [DATA_W-1:0]   w_quoFixed;
  logic [DATA_W-1:0]   w_remFixed;
  logic                w_lastStep;

  assign w_accept      = (r_state == DIV_IDLE) && (start_i == DivStart) && !annul_i;
  assign w_dividendNeg = signed_i & dividend_i[DATA_W-1];
  assign w_divisorNeg  = signed_i & divisor_i[DATA_W-1];
  assign w_dividendAbs = w_dividendNeg ? -dividend_i : dividend_i;
  assign w_divisorAbs  = w_divisorNeg  ? -divisor_i  : divisor_i;

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_stepRem),
    .o_quo    (w_stepQuo)
  );

  // Remainder takes the dividend's sign, quotient the XOR of both signs;
  // the fix is applied to the final step's output so END sees it directly.
  assign w_negQuo   = r_signed & (r_signDividend ^ r_signDivisor);
  assign w_negRem   = r_signed & r_signDividend;
  assign w_quoFixed = w_negQuo ? -w_stepQuo : w_stepQuo;
  assign w_remFixed = w_negRem ? -w_stepRem : w_stepRem;
  assign w_lastStep = r_cnt == CNT_W'(DATA_W - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= DIV_IDLE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_divisor      <= '0;
      r_signed       <= 1'b0;
      r_signDividend <= 1'b0;
      r_signDivisor  <= 1'b0;
      r_result       <= '0;
      r_ready        <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_signed       <= signed_i;
            r_signDividend <= w_dividendNeg;
            r_signDivisor  <= w_divisorNeg;
            if (divisor_i == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= '0;
              r_rem     <= '0;
              r_quo     <= w_dividendAbs;
              r_divisor <= w_divisorAbs;
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            r_state <= DIV_IDLE;
          end else begin
            r_state  <= DIV_END;
            r_result <= '0;
            r_ready  <= DivResultReady;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_stepRem;
            r_quo <= w_stepQuo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastStep) begin
              r_state  <= DIV_END;
              r_result <= {w_remFixed, w_quoFixed};
              r_ready  <= DivResultReady;
            end
          end
        end
        DIV_END: begin
          // EX holds start until it sees ready; dropping it releases the unit.
          if (annul_i || (start_i != DivStart)) begin
            r_state  <= DIV_IDLE;
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  assign stall_req_o = w_accept || (r_state == DIV_ON) || (r_state == DIV_BYZERO);

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: stimulus pushes reference results,
// a monitor pops and compares whenever ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  typedef struct {
    logic [63:0] result;
    int          issueCycle;
    int          latency;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  int      cycleCount = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Architectural definition of DIV/DIVU: truncating division on wide integers,
  // remainder follows the dividend, divide-by-zero yields all zeros.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected,
               cycleCount);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding request.
  initial begin
    expect_t e;
    logic    prevReady;
    prevReady = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && !prevReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReady: got ready_o=1 with result %h, expected no result",
                   result_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", result_o, e.result);
          checkOutput("latency", 64'(cycleCount - e.issueCycle), 64'(e.latency));
          checkOutput("stallInEnd", {63'd0, stall_req_o}, 64'd0);
        end
      end
      prevReady = (ready_o === 1'b1);
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input int holdExtra);
    expect_t e;
    logic    stallGap;
    int      n;
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = sgn;
    annul_i    = 1'b0;
    start_i    = 1'b1;
    e.result     = refDiv(a, b, sgn);
    e.issueCycle = cycleCount;
    e.latency    = (b == 32'd0) ? 2 : 33;
    expQ.push_back(e);
    #1;
    checkOutput("stallOnRequest", {63'd0, stall_req_o}, 64'd1);
    @(posedge clk);
    #1;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    signed_i   = 1'($urandom);
    stallGap = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      if (ready_o !== 1'b1 && stall_req_o !== 1'b1) stallGap = 1'b1;
      n++;
    end
    if (ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got no ready_o after %0d cycles, expected ready", n);
      expQ.delete();
    end
    checkOutput("stallDuringOp", {63'd0, stallGap}, 64'd0);
    for (int i = 0; i < holdExtra; i++) begin
      @(negedge clk);
      checkOutput("holdResult", {ready_o, 63'd0} | 64'(result_o == e.result),
                  {1'b1, 63'd1});
    end
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("dropStart", {ready_o, stall_req_o, 62'd0} | result_o, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    logic        sawReady;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState", {ready_o, stall_req_o, 62'd0} | result_o, 64'd0);
    rst = 1'b0;

    applyStimulus(32'd7, 32'd2, 1'b0, 2);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    applyStimulus(32'd5, 32'd0, 1'b0, 0);
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 1);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

    // Annul in cycle T+10: the unit must drop back to IDLE and never report.
    @(negedge clk);
    dividend_i = 32'd1234; divisor_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    checkOutput("annulIdle", {ready_o, stall_req_o, 62'd0} | result_o, 64'd0);
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1 || stall_req_o === 1'b1) sawReady = 1'b1;
    end
    checkOutput("annulQuiet", {63'd0, sawReady}, 64'd0);
    applyStimulus(32'd100, 32'd7, 1'b0, 0);

    // Reset in cycle T+5 of an operation wins over the running division.
    @(negedge clk);
    dividend_i = 32'd1000; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetMidOp", {ready_o, stall_req_o, 62'd0} | result_o, 64'd0);
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) sawReady = 1'b1;
    end
    checkOutput("resetQuiet", {63'd0, sawReady}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus(a, b, sgn, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
